stream_copy_engine: RTL and testbench
=====================================

STREAM_COPY_ENGINE -- requirements
Module: stream_copy_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, line width in bits (multiple of 32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 512, staging FIFO lines (power of 2, >= CHUNK_LINES).
REQ-003 SHALL have parameter CHUNK_LINES, default 64, max lines per read request.
REQ-004 SHALL have parameter LEN_WIDTH, default 16, width of line counts.
REQ-005 SHALL have ports clk input 1 (clock) and reset input 1 (reset); one clock, reset synchronous active-high.
REQ-006 SHALL have port start input 1, one-cycle pulse launching a copy.
REQ-007 SHALL have port num_lines input LEN_WIDTH, total lines to copy, sampled on accepted start.
REQ-008 SHALL have port mode input 2, transform: 0 pass, 1 bitwise invert, 2 per-32-bit-lane +1, 3 reserved (treated as pass); sampled on accepted start.
REQ-009 SHALL have ports src_buf and dst_buf input 1 each, buffer ids, sampled on accepted start.
REQ-010 SHALL have ports rd_req_valid output 1, rd_req_buf output 1, rd_req_len output LEN_WIDTH: read-stream request, one cycle per request.
REQ-011 SHALL have ports rd_rsp_valid input 1, rd_rsp_data input DATA_WIDTH: returned line, in order.
REQ-012 SHALL have ports wr_req_valid output 1, wr_req_buf output 1, wr_req_data output DATA_WIDTH, wr_fifo_full input 1.
REQ-013 SHALL have ports busy output 1, finish output 1, error output 1.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when all lines requested; DRAIN->DONE when written count equals num_lines; DONE->RUN on start.
REQ-015 SHALL ignore start in RUN and DRAIN (no parameter resample, no counter change).
REQ-016 SHALL, in RUN, issue a read of len = min(CHUNK_LINES, lines not yet requested) only when FIFO_DEPTH - fifo_occupancy - outstanding >= len; outstanding = requested - received.
REQ-017 SHALL issue at most one read request per cycle and never let outstanding + occupancy exceed FIFO_DEPTH.
REQ-018 SHALL register each rd_rsp_valid line, apply the transform, and enqueue it one cycle later.
REQ-019 SHALL transform mode 2 as independent 32-bit lane increments, wrapping 0xFFFFFFFF->0 with no carry across lanes.
REQ-020 SHALL dequeue when FIFO non-empty and wr_fifo_full low, and drive wr_req_valid with that line exactly one cycle after dequeue.
REQ-021 SHALL hold wr_req_valid low in all cycles without a dequeue in the prior cycle; wr_req_buf = sampled dst_buf.
REQ-022 SHALL count written lines as wr_req_valid cycles, width LEN_WIDTH+1 internally so count never wraps.
REQ-023 SHALL, for num_lines = 0, go RUN->DRAIN->DONE issuing no read and no write requests.
REQ-024 SHALL assert busy in RUN and DRAIN only; finish high exactly in DONE (sticky until next accepted start or reset).
REQ-025 SHALL set error sticky (cleared only by reset or accepted start) on rd_rsp_valid with outstanding = 0 and drop that line.
REQ-026 SHALL preserve line order end to end; no line dropped or duplicated under wr_fifo_full back-pressure of any length.

Reset
REQ-027 SHALL, on reset, enter IDLE; rd_req_valid, wr_req_valid, busy, finish, error = 0; rd_req_len, wr_req_data = 0; FIFO emptied; all counters 0.
REQ-028 SHALL, on reset mid-RUN/DRAIN, abandon the copy, ignore later responses for it without raising error, and await a new start.

Verification
REQ-029 num_lines=512, mode 0, no back-pressure -> 8 reads of len 64 to src_buf, 512 writes to dst_buf bit-identical in order, finish high, error 0.
REQ-030 num_lines=100, mode 2, line lanes 0xFFFFFFFF -> reads len 64 then 36; every output lane 0x00000000; 100 writes.
REQ-031 num_lines=1000, mode 1, wr_fifo_full high 300 cycles mid-run -> outstanding+occupancy never > 512, 1000 inverted lines in order.
REQ-032 num_lines=0 -> no rd/wr requests, finish high within 3 cycles of start.
REQ-033 start pulses during RUN plus stray rd_rsp_valid with outstanding 0 -> second start ignored, error=1, copy completes correctly.
REQ-034 reset asserted after 50 of 200 lines written -> all outputs 0 next cycle; new start with num_lines=10 -> exactly 10 writes, finish high.

Source files
------------

// File: rtl/stream_copy_engine.sv
// stream_copy_engine: copies num_lines lines from a source read stream to a
// destination write stream through a credit-managed staging FIFO, applying a
// simple per-line transform (pass / invert / per-32-bit-lane increment).
module stream_copy_engine #(
  parameter int DATA_WIDTH  = 512,
  parameter int FIFO_DEPTH  = 512,
  parameter int CHUNK_LINES = 64,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  num_lines,
  input  logic [1:0]            mode,
  input  logic                  src_buf,
  input  logic                  dst_buf,
  output logic                  rd_req_valid,
  output logic                  rd_req_buf,
  output logic [LEN_WIDTH-1:0]  rd_req_len,
  input  logic                  rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data,
  output logic                  wr_req_valid,
  output logic                  wr_req_buf,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_fifo_full,
  output logic                  busy,
  output logic                  finish,
  output logic                  error
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = LEN_WIDTH + 1;
  localparam int LANES = DATA_WIDTH / 32;
  localparam logic [31:0] DEPTH_C = 32'(FIFO_DEPTH);
  localparam logic [31:0] CHUNK_C = 32'(CHUNK_LINES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Line transform; mode 3 is reserved and behaves as pass-through.
  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                  input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] res;
    res = d;
    case (m)
      2'd1:    res = ~d;
      2'd2: begin
        for (int k = 0; k < LANES; k++) begin
          res[k*32 +: 32] = d[k*32 +: 32] + 32'd1;
        end
      end
      default: res = d;
    endcase
    return res;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LEN_WIDTH-1:0]    r_num_lines;
  logic [1:0]              r_mode;
  logic                    r_src_buf;
  logic                    r_dst_buf;
  logic [CW-1:0]           r_req_cnt;
  logic [CW-1:0]           r_rcv_cnt;
  logic [CW-1:0]           r_wr_cnt;
  logic                    r_rd_valid;
  logic [LEN_WIDTH-1:0]    r_rd_len;
  logic                    r_pipe_valid;
  logic [DATA_WIDTH-1:0]   r_pipe_data;
  logic [AW:0]             r_wptr;
  logic [AW:0]             r_rptr;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic                    r_wr_valid;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_busy;
  logic                    r_finish;
  logic                    r_error;
  logic                    r_quiet;

  logic                    w_start_acc;
  logic                    w_issue;
  logic [CW-1:0]           w_outstanding;
  logic [CW-1:0]           w_remaining;
  logic [CW-1:0]           w_len;
  logic [AW:0]             w_fifo_cnt;
  logic [31:0]             w_need;
  logic                    w_credit_ok;
  logic                    w_rsp_ok;
  logic                    w_stray;
  logic                    w_deq;

  assign w_start_acc   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_outstanding = r_req_cnt - r_rcv_cnt;
  assign w_remaining   = {1'b0, r_num_lines} - r_req_cnt;
  assign w_len         = (32'(w_remaining) > CHUNK_C) ? CW'(CHUNK_LINES) : w_remaining;
  assign w_fifo_cnt    = r_wptr - r_rptr;
  // The line held in the response register already owns a FIFO slot.
  assign w_need        = 32'(w_fifo_cnt) + {31'd0, r_pipe_valid} + 32'(w_outstanding) + 32'(w_len);
  assign w_credit_ok   = (w_need <= DEPTH_C);
  assign w_rsp_ok      = rd_rsp_valid && (w_outstanding != {CW{1'b0}});
  // After a reset the engine stays quiet about leftover responses of the
  // abandoned copy until a new copy is launched.
  assign w_stray       = rd_rsp_valid && (w_outstanding == {CW{1'b0}}) && !r_quiet;
  assign w_deq         = (w_fifo_cnt != {(AW+1){1'b0}}) && !wr_fifo_full;

  // Next-state and read-issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_remaining == {CW{1'b0}}) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_credit_ok) begin
          w_issue = 1'b1;
        end else begin
          w_issue = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (r_wr_cnt == {1'b0, r_num_lines}) w_state_nxt = ST_DONE;
        else                                 w_state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
        else       w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture copy parameters on an accepted start only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_lines <= {LEN_WIDTH{1'b0}};
      r_mode      <= 2'd0;
      r_src_buf   <= 1'b0;
      r_dst_buf   <= 1'b0;
    end else if (w_start_acc) begin
      r_num_lines <= num_lines;
      r_mode      <= mode;
      r_src_buf   <= src_buf;
      r_dst_buf   <= dst_buf;
    end
  end

  // Read request generation and requested-line count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_len   <= {LEN_WIDTH{1'b0}};
      r_req_cnt  <= {CW{1'b0}};
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) r_rd_len <= w_len[LEN_WIDTH-1:0];
      if (w_start_acc)  r_req_cnt <= {CW{1'b0}};
      else if (w_issue) r_req_cnt <= r_req_cnt + w_len;
    end
  end

  // Response capture: register, transform, and count accepted lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_valid <= 1'b0;
      r_pipe_data  <= {DATA_WIDTH{1'b0}};
      r_rcv_cnt    <= {CW{1'b0}};
    end else begin
      r_pipe_valid <= w_rsp_ok;
      if (w_rsp_ok) r_pipe_data <= xform(r_mode, rd_rsp_data);
      if (w_start_acc)   r_rcv_cnt <= {CW{1'b0}};
      else if (w_rsp_ok) r_rcv_cnt <= r_rcv_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Staging FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= {(AW+1){1'b0}};
      r_rptr <= {(AW+1){1'b0}};
    end else begin
      if (r_pipe_valid) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_deq)        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Staging FIFO storage (contents need no reset; pointers define validity).
  always_ff @(posedge clk) begin
    if (r_pipe_valid) r_mem[r_wptr[AW-1:0]] <= r_pipe_data;
  end

  // Write request: line appears one cycle after it is dequeued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_valid <= 1'b0;
      r_wr_data  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_wr_valid <= w_deq;
      if (w_deq) r_wr_data <= r_mem[r_rptr[AW-1:0]];
    end
  end

  // Written-line count, one extra bit wide so it cannot wrap.
  always_ff @(posedge clk) begin
    if (reset)            r_wr_cnt <= {CW{1'b0}};
    else if (w_start_acc) r_wr_cnt <= {CW{1'b0}};
    else if (r_wr_valid)  r_wr_cnt <= r_wr_cnt + {{(CW-1){1'b0}}, 1'b1};
  end

  // Status flags: busy/finish follow the next state, error is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
      r_error  <= 1'b0;
      r_quiet  <= 1'b1;
    end else begin
      r_busy   <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
      r_finish <= (w_state_nxt == ST_DONE);
      if (w_start_acc)  r_error <= 1'b0;
      else if (w_stray) r_error <= 1'b1;
      if (w_start_acc)  r_quiet <= 1'b0;
    end
  end

  assign rd_req_valid = r_rd_valid;
  assign rd_req_buf   = r_src_buf;
  assign rd_req_len   = r_rd_len;
  assign wr_req_valid = r_wr_valid;
  assign wr_req_buf   = r_dst_buf;
  assign wr_req_data  = r_wr_data;
  assign busy         = r_busy;
  assign finish       = r_finish;
  assign error        = r_error;

endmodule

// File: tb/tb_stream_copy_engine.sv
// Scoreboard bench for stream_copy_engine: the main process issues copies and
// pushes expected read requests / written lines; a negedge monitor pops and
// compares; a responder returns read data in order.
module tb_stream_copy_engine;
  localparam int DW = 512;
  localparam int LW = 16;
  localparam int FD = 512;
  localparam int CL = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] num_lines;
  logic [1:0]    mode;
  logic          src_buf;
  logic          dst_buf;
  logic          rd_req_valid;
  logic          rd_req_buf;
  logic [LW-1:0] rd_req_len;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          wr_req_valid;
  logic          wr_req_buf;
  logic [DW-1:0] wr_req_data;
  logic          wr_fifo_full;
  logic          busy;
  logic          finish;
  logic          error;

  always #5 clk = ~clk;

  stream_copy_engine #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CHUNK_LINES(CL), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines), .mode(mode),
    .src_buf(src_buf), .dst_buf(dst_buf),
    .rd_req_valid(rd_req_valid), .rd_req_buf(rd_req_buf), .rd_req_len(rd_req_len),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_buf(wr_req_buf), .wr_req_data(wr_req_data),
    .wr_fifo_full(wr_fifo_full), .busy(busy), .finish(finish), .error(error)
  );

  // status check kinds
  localparam int K_FINISH = 0, K_ERROR = 1, K_BUSY = 2, K_RSTZERO = 3, K_SBEMPTY = 4, K_INFL = 5;
  typedef struct {
    int            kind;
    logic [DW-1:0] exp;
    string         name;
  } chk_t;

  logic [DW:0]   exp_wr_q[$];
  logic [LW:0]   exp_rd_q[$];
  chk_t          chk_q[$];

  int n_pass = 0, n_total = 0;
  int wr_seen = 0, req_total = 0, max_infl = 0;
  int rsp_sent = 0, stray_done = 0;
  int line_base = 0, cur_test = 0, stray_req = 0;

  function automatic logic [DW-1:0] gen_line(input int t, input int i);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) begin
      if (t == 2)      d[k*32 +: 32] = 32'hFFFF_FFFF;
      else if (t == 6) d[k*32 +: 32] = (k % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0005;
      else             d[k*32 +: 32] = {8'(t), 16'(i), 8'(k)};
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (m == 2'd1) r = ~d;
    if (m == 2'd2) for (int k = 0; k < DW/32; k++) r[k*32 +: 32] = d[k*32 +: 32] + 32'd1;
    return r;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor/scoreboard: compares every DUT request and queued status checks.
  always @(negedge clk) begin
    logic [DW-1:0] a;
    chk_t          it;
    if (reset) begin
      exp_wr_q.delete();
      exp_rd_q.delete();
    end else begin
      if (rd_req_valid) begin
        req_total += int'(rd_req_len);
        if (exp_rd_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_req unexpected: got buf=%0d len=%0d", rd_req_buf, rd_req_len);
        end else begin
          a = '0; a[LW:0] = {rd_req_buf, rd_req_len};
          check("rd_req", a, DW'(exp_rd_q.pop_front()));
        end
      end
      if (wr_req_valid) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) begin
          n_total++;
          $display("FAIL wr_req unexpected: got buf=%0d data=%h", wr_req_buf, wr_req_data);
        end else begin
          logic [DW:0] e;
          e = exp_wr_q.pop_front();
          a = '0; a[0] = wr_req_buf;
          check("wr_buf", a, DW'(e[DW]));
          check("wr_data", wr_req_data, e[DW-1:0]);
        end
      end
      if (req_total - wr_seen > max_infl) max_infl = req_total - wr_seen;
    end
    while (chk_q.size() > 0) begin
      it = chk_q.pop_front();
      a = '0;
      case (it.kind)
        K_FINISH:  a[0] = finish;
        K_ERROR:   a[0] = error;
        K_BUSY:    a[0] = busy;
        K_RSTZERO: a = DW'({rd_req_valid, wr_req_valid, busy, finish, error, rd_req_len, |wr_req_data});
        K_SBEMPTY: a = DW'(exp_wr_q.size() + exp_rd_q.size());
        K_INFL:    a[0] = (max_infl <= FD);
        default:   a = '1;
      endcase
      check(it.name, a, it.exp);
    end
  end

  // Read responder: returns requested lines in order, with periodic gaps.
  initial begin
    int cyc;
    cyc = 0;
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (stray_req != stray_done) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = {16{32'hBAD0_BAD0}};
        stray_done++;
      end else if ((req_total > rsp_sent) && (cyc % 5 != 4)) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = gen_line(cur_test, rsp_sent - line_base);
        rsp_sent++;
      end else begin
        rd_rsp_valid = 1'b0;
      end
    end
  end

  task automatic push_chk(input int kind, input logic [DW-1:0] exp, input string nm);
    chk_t c;
    c.kind = kind; c.exp = exp; c.name = nm;
    chk_q.push_back(c);
  endtask

  task automatic run_copy(input int t, input int n, input logic [1:0] m, input logic s, input logic d);
    int rem, l;
    logic [DW-1:0] e;
    cur_test  = t;
    line_base = rsp_sent;
    rem = n;
    while (rem > 0) begin
      l = (rem > CL) ? CL : rem;
      exp_rd_q.push_back({s, LW'(l)});
      rem -= l;
    end
    for (int i = 0; i < n; i++) begin
      if (t == 2) e = '0;
      else if (t == 6) begin
        for (int k = 0; k < DW/32; k++) e[k*32 +: 32] = (k % 2 == 0) ? 32'h0000_0000 : 32'h0000_0006;
      end else e = model(m, gen_line(t, i));
      exp_wr_q.push_back({d, e});
    end
    @(posedge clk); #1;
    start = 1'b1; num_lines = LW'(n); mode = m; src_buf = s; dst_buf = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input logic exp_err, input string nm);
    for (int c = 0; c < 5000 && finish !== 1'b1; c++) @(negedge clk);
    push_chk(K_FINISH, DW'(1), {nm, " finish"});
    push_chk(K_ERROR, DW'(exp_err), {nm, " error"});
    push_chk(K_BUSY, DW'(0), {nm, " busy"});
    push_chk(K_SBEMPTY, DW'(0), {nm, " all lines seen"});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; num_lines = '0; mode = 2'd0;
    src_buf = 1'b0; dst_buf = 1'b0; wr_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_chk(K_RSTZERO, DW'(0), "reset outputs");
    reset = 1'b0;
    @(negedge clk);

    // 512 lines, pass
    run_copy(1, 512, 2'd0, 1'b1, 1'b0);
    push_chk(K_BUSY, DW'(1), "t1 busy");
    wait_finish(1'b0, "t1");

    // 100 lines all-ones lanes, +1 per lane
    run_copy(2, 100, 2'd2, 1'b0, 1'b1);
    wait_finish(1'b0, "t2");

    // 1000 lines invert with 300 cycles of back-pressure
    base = wr_seen;
    run_copy(3, 1000, 2'd1, 1'b0, 1'b1);
    for (int c = 0; c < 3000 && wr_seen - base < 200; c++) @(negedge clk);
    @(posedge clk); #1 wr_fifo_full = 1'b1;
    repeat (300) @(posedge clk);
    #1 wr_fifo_full = 1'b0;
    wait_finish(1'b0, "t3");
    push_chk(K_INFL, DW'(1), "t3 outstanding+occupancy bound");

    // zero-length copy
    run_copy(4, 0, 2'd0, 1'b1, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    push_chk(K_FINISH, DW'(1), "t4 finish by 3 cycles");
    wait_finish(1'b0, "t4");

    // stray response and ignored start while stalled in RUN
    base = req_total;
    @(posedge clk); #1 wr_fifo_full = 1'b1;
    run_copy(5, 600, 2'd0, 1'b1, 1'b0);
    for (int c = 0; c < 3000 && !((req_total - base >= 512) && (req_total == rsp_sent)); c++) @(negedge clk);
    repeat (4) @(negedge clk);
    push_chk(K_BUSY, DW'(1), "t5 busy stalled");
    push_chk(K_ERROR, DW'(0), "t5 error before stray");
    stray_req++;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; num_lines = LW'(5); mode = 2'd1; src_buf = 1'b0; dst_buf = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_chk(K_ERROR, DW'(1), "t5 error after stray");
    push_chk(K_BUSY, DW'(1), "t5 busy after ignored start");
    @(posedge clk); #1 wr_fifo_full = 1'b0;
    wait_finish(1'b1, "t5");

    // mixed lanes with +1: no carry between lanes
    run_copy(6, 3, 2'd2, 1'b0, 1'b0);
    wait_finish(1'b0, "t6");

    // reserved mode behaves as pass
    run_copy(7, 4, 2'd3, 1'b1, 1'b1);
    wait_finish(1'b0, "t7");

    // reset after 50 of 200 lines written, then a fresh 10-line copy
    base = wr_seen;
    run_copy(8, 200, 2'd0, 1'b0, 1'b1);
    for (int c = 0; c < 3000 && wr_seen - base < 50; c++) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    push_chk(K_RSTZERO, DW'(0), "t8 outputs after reset");
    for (int c = 0; c < 3000 && req_total != rsp_sent; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    push_chk(K_ERROR, DW'(0), "t8 no error on abandoned responses");
    push_chk(K_FINISH, DW'(0), "t8 finish low after reset");
    push_chk(K_BUSY, DW'(0), "t8 busy low after reset");
    @(negedge clk);
    run_copy(9, 10, 2'd1, 1'b1, 1'b0);
    wait_finish(1'b0, "t9");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
